// File: rtl/demux3_buf_pkg.sv
// ----------------------------------------------------------------------------
// demux3_buf_pkg
// Shared definitions for the 3-way result demultiplexer.
//  - sel_e        : destination select, same encoding as the result-select mux
//  - NUM_CH       : number of output channels
//  - route_onehot : maps a select code to a one-hot channel vector (a=bit0,
//                   b=bit1, c=bit2); SEL_BAD falls through to channel a, the
//                   same as the mux default arm
// ----------------------------------------------------------------------------
package demux3_buf_pkg;

    typedef enum logic [1:0] {
        SEL_A   = 2'b00,
        SEL_B   = 2'b01,
        SEL_C   = 2'b10,
        SEL_BAD = 2'b11
    } sel_e;

    localparam int NUM_CH = 3;

    function automatic logic [NUM_CH-1:0] route_onehot(input sel_e sel);
        logic [NUM_CH-1:0] oh;
        case (sel)
            SEL_B:   oh = 3'b010;
            SEL_C:   oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage : demux3_buf_pkg

// File: rtl/demux_slot.sv
// ----------------------------------------------------------------------------
// demux_slot
// One output channel of demux3_buf: a single-entry holding register with a
// valid flag, a valid/ready output handshake, and a wrapping count of beats
// consumed by the sink.
//
// Ports
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  load       in   1         write load_data into the slot this cycle
//  load_data  in   Width     beat to hold
//  can_load   out  1         slot empty, or its beat leaves this cycle
//  out_valid  out  1         slot holds a beat
//  out_ready  in   1         sink consumes
//  out_data   out  Width     held beat
//  cnt        out  CntWidth  beats consumed, wraps silently
// ----------------------------------------------------------------------------
module demux_slot #(
    parameter int Width    = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [Width-1:0]    load_data,
    output logic                can_load,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Width-1:0]    out_data,
    output logic [CntWidth-1:0] cnt
);

    logic consume;

    assign consume  = out_valid & out_ready;
    // A full slot can still take a new beat in the same cycle its current one
    // drains, which is what lets back-to-back streaming run at full rate.
    assign can_load = ~out_valid | out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: the payload register is reset too, because sinks see out_data=0
    // after reset; a pure datapath register would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (consume) begin
            cnt <= cnt + CntWidth'(1);
        end
    end

endmodule : demux_slot

// File: rtl/demux3_buf.sv
// ----------------------------------------------------------------------------
// demux3_buf
// Steers one producer stream to one of three consumers (a/b/c). Each channel
// is a registered one-entry buffer with valid/ready handshakes on both sides
// and a per-channel consumed-beat counter.
//
// Optional feature, macro DEMUX3_SEL_CHECK_EN:
//  defined   - in_sel=2'b11 beats are accepted and dropped; sel_err is set
//              the next cycle and held until reset.
//  undefined - in_sel=2'b11 routes to channel a; sel_err is tied 0.
//
// Ports
//  clk, rst_n                          clock, async active-low reset
//  in_valid/in_ready/in_data/in_sel    producer handshake, payload, select
//  out_{a,b,c}_valid/ready/data        per-channel consumer handshake
//  cnt_a/cnt_b/cnt_c                   beats consumed per channel
//  sel_err                             sticky illegal-select flag
// ----------------------------------------------------------------------------
module demux3_buf
    import demux3_buf_pkg::*;
#(
    parameter int Width    = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Width-1:0]    in_data,
    input  logic [1:0]          in_sel,
    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [Width-1:0]    out_a_data,
    output logic                out_b_valid,
    input  logic                out_b_ready,
    output logic [Width-1:0]    out_b_data,
    output logic                out_c_valid,
    input  logic                out_c_ready,
    output logic [Width-1:0]    out_c_data,
    output logic [CntWidth-1:0] cnt_a,
    output logic [CntWidth-1:0] cnt_b,
    output logic [CntWidth-1:0] cnt_c,
    output logic                sel_err
);

    sel_e              sel;
    logic [NUM_CH-1:0] tgt;
    logic [NUM_CH-1:0] can_load;
    logic [NUM_CH-1:0] load;
    logic              bad;

    assign sel = sel_e'(in_sel);
    assign tgt = route_onehot(sel);

`ifdef DEMUX3_SEL_CHECK_EN
    assign bad = (sel == SEL_BAD);
`else
    assign bad = 1'b0;
`endif

    // in_ready looks only at the addressed slot (and never at in_valid), so a
    // stalled channel never blocks traffic to the others. An illegal select is
    // always ready so the producer is not wedged by a beat that will be dropped.
    assign in_ready = rst_n & (bad | (|(tgt & can_load)));

    // Gating with in_valid first keeps an unknown in_sel/in_data from reaching
    // any slot while the producer is idle.
    assign load = (in_valid & in_ready & ~bad) ? tgt : '0;

    demux_slot #(.Width(Width), .CntWidth(CntWidth)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[0]),
        .load_data (in_data),
        .can_load  (can_load[0]),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .out_data  (out_a_data),
        .cnt       (cnt_a)
    );

    demux_slot #(.Width(Width), .CntWidth(CntWidth)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[1]),
        .load_data (in_data),
        .can_load  (can_load[1]),
        .out_valid (out_b_valid),
        .out_ready (out_b_ready),
        .out_data  (out_b_data),
        .cnt       (cnt_b)
    );

    demux_slot #(.Width(Width), .CntWidth(CntWidth)) u_slot_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[2]),
        .load_data (in_data),
        .can_load  (can_load[2]),
        .out_valid (out_c_valid),
        .out_ready (out_c_ready),
        .out_data  (out_c_data),
        .cnt       (cnt_c)
    );

`ifdef DEMUX3_SEL_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (in_valid && bad) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule : demux3_buf

// File: tb/tb_demux3_buf.sv
// ----------------------------------------------------------------------------
// tb_demux3_buf
// Self-checking bench for demux3_buf (CntWidth=4 so counter wrap is reachable).
// A queue-based model of the three channels is compared with the DUT on every
// falling edge; directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_demux3_buf;

    localparam int W  = 32;
    localparam int CW = 4;
`ifdef DEMUX3_SEL_CHECK_EN
    localparam bit SEL_CHECK = 1'b1;
`else
    localparam bit SEL_CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          out_a_valid, out_b_valid, out_c_valid;
    logic          out_a_ready, out_b_ready, out_c_ready;
    logic [W-1:0]  out_a_data, out_b_data, out_c_data;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c;
    logic          sel_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    demux3_buf #(.Width(W), .CntWidth(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_a_data  (out_a_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .out_b_data  (out_b_data),
        .out_c_valid (out_c_valid),
        .out_c_ready (out_c_ready),
        .out_c_data  (out_c_data),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b),
        .cnt_c       (cnt_c),
        .sel_err     (sel_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is a FIFO of beats awaiting their sink; capacity is one.
    logic [W-1:0]  qa[$], qb[$], qc[$];
    logic [CW-1:0] mcnt_a = '0, mcnt_b = '0, mcnt_c = '0;
    bit            msel_err = 1'b0;

    function automatic int target(input logic [1:0] s);
        return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 0;
    endfunction

    function automatic int qsize(input int c);
        return (c == 0) ? qa.size() : (c == 1) ? qb.size() : qc.size();
    endfunction

    function automatic bit sink_ready(input int c);
        return (c == 0) ? out_a_ready : (c == 1) ? out_b_ready : out_c_ready;
    endfunction

    function automatic bit exp_ready();
        if (rst_n !== 1'b1) return 1'b0;
        if (SEL_CHECK && in_sel == 2'd3) return 1'b1;
        return qsize(target(in_sel)) == 0 || sink_ready(target(in_sel));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit drop;
        if (!rst_n) begin
            qa.delete(); qb.delete(); qc.delete();
            mcnt_a = '0; mcnt_b = '0; mcnt_c = '0;
            msel_err = 1'b0;
        end else begin
            acc  = in_valid && exp_ready();
            drop = SEL_CHECK && in_sel == 2'd3;
            if (qa.size() > 0 && out_a_ready) begin void'(qa.pop_front()); mcnt_a++; end
            if (qb.size() > 0 && out_b_ready) begin void'(qb.pop_front()); mcnt_b++; end
            if (qc.size() > 0 && out_c_ready) begin void'(qc.pop_front()); mcnt_c++; end
            if (acc && !drop) begin
                case (target(in_sel))
                    1:       qb.push_back(in_data);
                    2:       qc.push_back(in_data);
                    default: qa.push_back(in_data);
                endcase
            end
            if (in_valid && drop) msel_err = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("in_ready", in_ready, exp_ready());
        check("a_valid", out_a_valid, qa.size() > 0);
        check("b_valid", out_b_valid, qb.size() > 0);
        check("c_valid", out_c_valid, qc.size() > 0);
        if (qa.size() > 0) check("a_data", out_a_data, qa[0]);
        if (qb.size() > 0) check("b_data", out_b_data, qb[0]);
        if (qc.size() > 0) check("c_data", out_c_data, qc[0]);
        check("cnt_a", cnt_a, mcnt_a);
        check("cnt_b", cnt_b, mcnt_b);
        check("cnt_c", cnt_c, mcnt_c);
        check("sel_err", sel_err, msel_err);
    end

    // Inputs change 2 time units after the rising edge, well away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_a_valid"}, out_a_valid, 1'b0);
        check({tag, "_b_valid"}, out_b_valid, 1'b0);
        check({tag, "_c_valid"}, out_c_valid, 1'b0);
        check({tag, "_a_data"}, out_a_data, 32'h0);
        check({tag, "_b_data"}, out_b_data, 32'h0);
        check({tag, "_cnt_a"}, cnt_a, 4'd0);
        check({tag, "_cnt_b"}, cnt_b, 4'd0);
        check({tag, "_sel_err"}, sel_err, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
        out_a_ready = 1'b0; out_b_ready = 1'b0; out_c_ready = 1'b0;
        repeat (2) step();
        check_all_reset("por");
        rst_n = 1'b1;

        // Streaming 1..8 to b at full rate.
        out_b_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            in_valid = 1'b1; in_sel = 2'd1; in_data = W'(i);
            #1 check("stream_in_ready", in_ready, 1'b1);
        end
        step();
        in_valid = 1'b0; in_data = 'x;
        #1 check("stream_last", out_b_data, 32'd8);
        step(); step();
        check("stream_cnt_b", cnt_b, 4'd8);
        in_data = '0;

        // Backpressure on a.
        out_a_ready = 1'b0;
        step();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA5;
        #1 check("bp_first_ready", in_ready, 1'b1);
        step();
        in_data = 32'h5A;
        #1 check("bp_block", in_ready, 1'b0);
        check("bp_held0", out_a_data, 32'hA5);
        step();
        #1 check("bp_still_block", in_ready, 1'b0);
        check("bp_held1", out_a_data, 32'hA5);
        out_a_ready = 1'b1;
        #1 check("bp_release", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #1 check("bp_second", out_a_data, 32'h5A);
        check("bp_second_valid", out_a_valid, 1'b1);
        step();
        #1 check("bp_drained", out_a_valid, 1'b0);
        check("bp_cnt_a", cnt_a, 4'd2);

        // Independence: a stalled and full, c still accepts.
        out_a_ready = 1'b0;
        step();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h11;
        step();
        in_sel = 2'd2; in_data = 32'h77;
        #1 check("indep_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #1 check("indep_c_valid", out_c_valid, 1'b1);
        check("indep_c_data", out_c_data, 32'h77);
        check("indep_a_data", out_a_data, 32'h11);
        out_a_ready = 1'b1; out_c_ready = 1'b1;
        step(); step();
        check("indep_cnt_c", cnt_c, 4'd1);
        check("indep_cnt_a", cnt_a, 4'd3);

        // Illegal select.
        out_a_ready = 1'b0;
        step();
        in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hDEAD;
        #1 check("bad_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0; in_sel = 2'd0;
`ifdef DEMUX3_SEL_CHECK_EN
        #1 check("bad_dropped", out_a_valid, 1'b0);
        check("bad_err", sel_err, 1'b1);
        step(); step();
        check("bad_err_sticky", sel_err, 1'b1);
`else
        #1 check("bad_to_a_valid", out_a_valid, 1'b1);
        check("bad_to_a_data", out_a_data, 32'hDEAD);
        check("bad_no_err", sel_err, 1'b0);
`endif
        out_a_ready = 1'b1;
        step(); step();

        // Reset mid-operation with beats held in a and b.
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        step();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h1;
        step();
        in_sel = 2'd1; in_data = 32'h2;
        step();
        in_valid = 1'b0;
        #1 check("pre_rst_a", out_a_valid, 1'b1);
        check("pre_rst_b", out_b_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_all_reset("async_rst");
        step(); step();
        rst_n = 1'b1;
        out_a_ready = 1'b1; out_b_ready = 1'b1;
        step();
        #1 check("post_rst_no_beat", out_a_valid, 1'b0);

        // Counter wrap: 17 beats to a with CntWidth=4.
        for (int i = 0; i < 17; i++) begin
            step();
            in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h100 + W'(i);
        end
        step();
        in_valid = 1'b0;
        step();
        #1 check("wrap_cnt_a", cnt_a, 4'd1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_demux3_buf
